// File: rtl/zigzag_yerlestirici.sv
// ---------------------------------------------------------------------------
// zigzag_yerlestirici
//
// Turns (run, value) pairs from the Huffman decoder into (row, col, value)
// coefficient writes for an N x N block (N = BLOCK_DIM, power of two, 2..16).
// Positions come from an incremental zigzag walker, not a ROM.
//
// A pair skips 'run' positions and then places its value. A pair flagged
// blok_son closes the block. A pair whose run would push past the last
// position of the block is dropped, and it raises a sticky error flag.
//
// Optional feature macro: ZZ_ZERO_FILL_EN
//   defined   : skipped positions are emitted as zero beats, and a block
//               closed early is padded with zeros up to position N*N-1, so
//               every block yields exactly N*N beats.
//   undefined : skipped positions advance silently, one cycle each.
//
// Ports
//   clk_i, rstn_i        clock, synchronous active-low reset
//   hd_run_i             zero positions preceding this value
//   hd_veri_i            coefficient value
//   hd_blok_son_i        last pair of the block (sampled with the pair)
//   hd_gecerli_i         pair valid
//   hd_hazir_o           pair accepted when high with hd_gecerli_i
//   ct_veri_o            coefficient
//   ct_row_o, ct_col_o   coefficient position
//   ct_gecerli_o         coefficient valid
//   ct_blok_son_o        last beat of the block
//   ct_hazir_i           downstream ready
//   hata_o               sticky run-overflow flag (cleared only by reset)
// ---------------------------------------------------------------------------
module zigzag_yerlestirici #(
  parameter  int BLOCK_DIM = 8,
  parameter  int RUN_W     = 6,
  parameter  int DATA_W    = 12,
  localparam int IDX_W     = $clog2(BLOCK_DIM)
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic [RUN_W-1:0]  hd_run_i,
  input  logic [DATA_W-1:0] hd_veri_i,
  input  logic              hd_blok_son_i,
  input  logic              hd_gecerli_i,
  output logic              hd_hazir_o,
  output logic [DATA_W-1:0] ct_veri_o,
  output logic [IDX_W-1:0]  ct_row_o,
  output logic [IDX_W-1:0]  ct_col_o,
  output logic              ct_gecerli_o,
  output logic              ct_blok_son_o,
  input  logic              ct_hazir_i,
  output logic              hata_o
);

  localparam int POS_W = 2 * IDX_W;
  // The overflow sum is sized to hold both operands without truncation, so a
  // wide run field cannot wrap around and hide an overflow on small blocks.
  localparam int SUM_W = ((POS_W > RUN_W) ? POS_W : RUN_W) + 1;

  localparam logic [POS_W-1:0] LAST_POS = POS_W'(BLOCK_DIM * BLOCK_DIM - 1);
  localparam logic [SUM_W-1:0] LAST_SUM = SUM_W'(BLOCK_DIM * BLOCK_DIM - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_DIM - 1);
  localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);
  localparam logic [POS_W-1:0] ONE_POS  = POS_W'(1);
  localparam logic [RUN_W-1:0] ONE_RUN  = RUN_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
`ifdef ZZ_ZERO_FILL_EN
    ST_FILL = 2'd2,
`endif
    ST_WALK = 2'd1
  } state_t;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t            r_state;
  logic [IDX_W-1:0]  r_row, r_col;
  logic [POS_W-1:0]  r_pos;
  logic [RUN_W-1:0]  r_skip;
  logic [DATA_W-1:0] r_val;
  logic              r_son;
  logic [DATA_W-1:0] r_ct_veri;
  logic [IDX_W-1:0]  r_ct_row, r_ct_col;
  logic              r_ct_vld, r_ct_son;
  logic              r_hata;

  state_t            w_state_nx;
  logic [IDX_W-1:0]  w_row_nx, w_col_nx;
  logic [POS_W-1:0]  w_pos_nx;
  logic [RUN_W-1:0]  w_skip_nx;
  logic [DATA_W-1:0] w_val_nx;
  logic              w_son_nx;
  logic [DATA_W-1:0] w_ct_veri_nx;
  logic [IDX_W-1:0]  w_ct_row_nx, w_ct_col_nx;
  logic              w_ct_vld_nx, w_ct_son_nx;
  logic              w_hata_nx;
  logic              w_hazir;

  // -------------------------------------------------------------------------
  // Zigzag walker: one step from (r_row, r_col, r_pos)
  // -------------------------------------------------------------------------
  logic [IDX_W-1:0] w_step_row, w_step_col;
  logic [POS_W-1:0] w_step_pos;
  logic             w_at_last;

  assign w_at_last = (r_pos == LAST_POS);

  always_comb begin : walker_step
    w_step_row = r_row;
    w_step_col = r_col;
    w_step_pos = r_pos + ONE_POS;
    if (w_at_last) begin
      w_step_row = '0;
      w_step_col = '0;
      w_step_pos = '0;
    end else if ((r_row[0] ^ r_col[0]) == 1'b0) begin
      // even anti-diagonal: moving up-right
      if (r_col == LAST_IDX)      w_step_row = r_row + ONE_IDX;
      else if (r_row == '0)       w_step_col = r_col + ONE_IDX;
      else begin
        w_step_row = r_row - ONE_IDX;
        w_step_col = r_col + ONE_IDX;
      end
    end else begin
      // odd anti-diagonal: moving down-left
      if (r_row == LAST_IDX)      w_step_col = r_col + ONE_IDX;
      else if (r_col == '0)       w_step_row = r_row + ONE_IDX;
      else begin
        w_step_row = r_row + ONE_IDX;
        w_step_col = r_col - ONE_IDX;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Overflow check for the pair offered this cycle. In IDLE the pair starts
  // at the current position; in the WALK emit cycle the current position is
  // being consumed, so the pair starts at the stepped position.
  // -------------------------------------------------------------------------
  logic             w_free;
  logic [POS_W-1:0] w_acc_pos;
  logic [SUM_W-1:0] w_sum;
  logic             w_ovf;

  assign w_free    = !r_ct_vld || ct_hazir_i;
  assign w_acc_pos = (r_state == ST_IDLE) ? r_pos : w_step_pos;
  assign w_sum     = SUM_W'(w_acc_pos) + SUM_W'(hd_run_i);
  assign w_ovf     = (w_sum > LAST_SUM);

  // -------------------------------------------------------------------------
  // Next-state / output logic
  // -------------------------------------------------------------------------
  always_comb begin : fsm_comb
    w_state_nx   = r_state;
    w_row_nx     = r_row;
    w_col_nx     = r_col;
    w_pos_nx     = r_pos;
    w_skip_nx    = r_skip;
    w_val_nx     = r_val;
    w_son_nx     = r_son;
    w_ct_veri_nx = r_ct_veri;
    w_ct_row_nx  = r_ct_row;
    w_ct_col_nx  = r_ct_col;
    // a completed handshake leaves a bubble unless a new beat is loaded below
    w_ct_vld_nx  = r_ct_vld & ~ct_hazir_i;
    w_ct_son_nx  = r_ct_son & ~ct_hazir_i;
    w_hata_nx    = r_hata;
    w_hazir      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_hazir = 1'b1;
        if (hd_gecerli_i) begin
          if (w_ovf) begin
            w_hata_nx = 1'b1;
            w_row_nx  = '0;
            w_col_nx  = '0;
            w_pos_nx  = '0;
          end else begin
            w_val_nx   = hd_veri_i;
            w_son_nx   = hd_blok_son_i;
            w_skip_nx  = hd_run_i;
            w_state_nx = ST_WALK;
          end
        end
      end

      ST_WALK: begin
        if (w_free) begin
          if (r_skip != '0) begin
            w_row_nx  = w_step_row;
            w_col_nx  = w_step_col;
            w_pos_nx  = w_step_pos;
            w_skip_nx = r_skip - ONE_RUN;
`ifdef ZZ_ZERO_FILL_EN
            w_ct_vld_nx  = 1'b1;
            w_ct_veri_nx = '0;
            w_ct_row_nx  = r_row;
            w_ct_col_nx  = r_col;
            w_ct_son_nx  = 1'b0;
`endif
          end else begin
            w_ct_vld_nx  = 1'b1;
            w_ct_veri_nx = r_val;
            w_ct_row_nx  = r_row;
            w_ct_col_nx  = r_col;
            w_ct_son_nx  = r_son | w_at_last;
            if (r_son) begin
`ifdef ZZ_ZERO_FILL_EN
              // keep walking so the padding continues from the next slot;
              // at the last slot the step wraps to (0,0) by itself
              w_row_nx   = w_step_row;
              w_col_nx   = w_step_col;
              w_pos_nx   = w_step_pos;
              w_state_nx = w_at_last ? ST_IDLE : ST_FILL;
`else
              w_row_nx   = '0;
              w_col_nx   = '0;
              w_pos_nx   = '0;
              w_state_nx = ST_IDLE;
`endif
            end else begin
              w_row_nx = w_step_row;
              w_col_nx = w_step_col;
              w_pos_nx = w_step_pos;
              // the next pair can be taken in the same cycle for 1 beat/clk
              w_hazir  = 1'b1;
              if (hd_gecerli_i) begin
                if (w_ovf) begin
                  w_hata_nx  = 1'b1;
                  w_row_nx   = '0;
                  w_col_nx   = '0;
                  w_pos_nx   = '0;
                  w_state_nx = ST_IDLE;
                end else begin
                  w_val_nx  = hd_veri_i;
                  w_son_nx  = hd_blok_son_i;
                  w_skip_nx = hd_run_i;
                end
              end else begin
                w_state_nx = ST_IDLE;
              end
            end
          end
        end
      end

`ifdef ZZ_ZERO_FILL_EN
      ST_FILL: begin
        if (w_free) begin
          w_ct_vld_nx  = 1'b1;
          w_ct_veri_nx = '0;
          w_ct_row_nx  = r_row;
          w_ct_col_nx  = r_col;
          w_ct_son_nx  = w_at_last;
          w_row_nx     = w_step_row;
          w_col_nx     = w_step_col;
          w_pos_nx     = w_step_pos;
          if (w_at_last) w_state_nx = ST_IDLE;
        end
      end
`endif

      default: w_state_nx = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_state   <= ST_IDLE;
      r_row     <= '0;
      r_col     <= '0;
      r_pos     <= '0;
      r_skip    <= '0;
      r_val     <= '0;
      r_son     <= 1'b0;
      r_ct_veri <= '0;
      r_ct_row  <= '0;
      r_ct_col  <= '0;
      r_ct_vld  <= 1'b0;
      r_ct_son  <= 1'b0;
      r_hata    <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_row     <= w_row_nx;
      r_col     <= w_col_nx;
      r_pos     <= w_pos_nx;
      r_skip    <= w_skip_nx;
      r_val     <= w_val_nx;
      r_son     <= w_son_nx;
      r_ct_veri <= w_ct_veri_nx;
      r_ct_row  <= w_ct_row_nx;
      r_ct_col  <= w_ct_col_nx;
      r_ct_vld  <= w_ct_vld_nx;
      r_ct_son  <= w_ct_son_nx;
      r_hata    <= w_hata_nx;
    end
  end

  assign hd_hazir_o    = w_hazir;
  assign ct_veri_o     = r_ct_veri;
  assign ct_row_o      = r_ct_row;
  assign ct_col_o      = r_ct_col;
  assign ct_gecerli_o  = r_ct_vld;
  assign ct_blok_son_o = r_ct_son;
  assign hata_o        = r_hata;

endmodule

// File: tb/tb_zigzag_yerlestirici.sv
// Directed bench for zigzag_yerlestirici: an 8x8 instance (a_*) and a 4x4
// instance (b_*) share one clock and reset.
module tb_zigzag_yerlestirici;
  typedef struct { int row; int col; int val; int son; } beat_t;
  typedef struct { int run; int val; int son; int er; int ec; int ev; int es; } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn;

  logic [5:0]  a_run;  logic [11:0] a_veri; logic a_bson, a_vld, a_rdy;
  logic [11:0] a_ct_veri; logic [2:0] a_ct_row, a_ct_col;
  logic a_ct_vld, a_ct_bson, a_ct_rdy, a_hata;

  logic [5:0]  b_run;  logic [11:0] b_veri; logic b_bson, b_vld, b_rdy;
  logic [11:0] b_ct_veri; logic [1:0] b_ct_row, b_ct_col;
  logic b_ct_vld, b_ct_bson, b_ct_rdy, b_hata;

  zigzag_yerlestirici #(.BLOCK_DIM(8), .RUN_W(6), .DATA_W(12)) u_dut8 (
    .clk_i(clk), .rstn_i(rstn),
    .hd_run_i(a_run), .hd_veri_i(a_veri), .hd_blok_son_i(a_bson),
    .hd_gecerli_i(a_vld), .hd_hazir_o(a_rdy),
    .ct_veri_o(a_ct_veri), .ct_row_o(a_ct_row), .ct_col_o(a_ct_col),
    .ct_gecerli_o(a_ct_vld), .ct_blok_son_o(a_ct_bson), .ct_hazir_i(a_ct_rdy),
    .hata_o(a_hata));

  zigzag_yerlestirici #(.BLOCK_DIM(4), .RUN_W(6), .DATA_W(12)) u_dut4 (
    .clk_i(clk), .rstn_i(rstn),
    .hd_run_i(b_run), .hd_veri_i(b_veri), .hd_blok_son_i(b_bson),
    .hd_gecerli_i(b_vld), .hd_hazir_o(b_rdy),
    .ct_veri_o(b_ct_veri), .ct_row_o(b_ct_row), .ct_col_o(b_ct_col),
    .ct_gecerli_o(b_ct_vld), .ct_blok_son_o(b_ct_bson), .ct_hazir_i(b_ct_rdy),
    .hata_o(b_hata));

  int n_chk  = 0;
  int n_fail = 0;
  beat_t qa[$];
  beat_t qb[$];

  // beat collectors: a beat counts when valid and ready meet at an edge
  always @(negedge clk) begin
    if (rstn) begin
      if (a_ct_vld && a_ct_rdy)
        qa.push_back('{int'(a_ct_row), int'(a_ct_col), int'(a_ct_veri), int'(a_ct_bson)});
      if (b_ct_vld && b_ct_rdy)
        qb.push_back('{int'(b_ct_row), int'(b_ct_col), int'(b_ct_veri), int'(b_ct_bson)});
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    a_vld = 1'b0; b_vld = 1'b0;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    qa.delete(); qb.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int sel, input int run, input int val, input int son);
    int n = 0;
    @(negedge clk);
    if (sel == 0) begin a_run = 6'(run); a_veri = 12'(val); a_bson = 1'(son); a_vld = 1'b1; end
    else          begin b_run = 6'(run); b_veri = 12'(val); b_bson = 1'(son); b_vld = 1'b1; end
    while (((sel == 0) ? a_rdy : b_rdy) !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", int'(n < 200), 1);
    @(posedge clk);
    #1;
    a_vld = 1'b0; b_vld = 1'b0;
  endtask

  task automatic cmp_q(input string tag, input int sel, input vec_t v[$]);
    int sz = (sel == 0) ? qa.size() : qb.size();
    chk({tag, "_count"}, sz, v.size());
    for (int i = 0; i < v.size() && i < sz; i++) begin
      beat_t bt = (sel == 0) ? qa[i] : qb[i];
      chk($sformatf("%s[%0d].row", tag, i), bt.row, v[i].er);
      chk($sformatf("%s[%0d].col", tag, i), bt.col, v[i].ec);
      chk($sformatf("%s[%0d].val", tag, i), bt.val, v[i].ev);
      chk($sformatf("%s[%0d].son", tag, i), bt.son, v[i].es);
    end
  endtask

  initial begin
    vec_t t1[$];
    vec_t t3[$];
    vec_t t5[$];
    int r4[16] = '{0,0,1,2,1,0,0,1,2,3,3,2,1,2,3,3};
    int c4[16] = '{0,1,0,0,1,2,3,2,1,0,1,2,3,3,2,3};
    int r8[8]  = '{0,0,1,2,1,0,0,1};
    int c8[8]  = '{0,1,0,0,1,2,3,2};
    int lat;

    a_run = '0; a_veri = '0; a_bson = 1'b0; a_vld = 1'b0; a_ct_rdy = 1'b1;
    b_run = '0; b_veri = '0; b_bson = 1'b0; b_vld = 1'b0; b_ct_rdy = 1'b1;
    do_reset();

    // reset state
    chk("rst_hd_hazir",  int'(a_rdy),     1);
    chk("rst_ct_vld",    int'(a_ct_vld),  0);
    chk("rst_ct_son",    int'(a_ct_bson), 0);
    chk("rst_hata",      int'(a_hata),    0);
    chk("rst_ct_veri",   int'(a_ct_veri), 0);
    chk("rst_ct_row",    int'(a_ct_row),  0);
    chk("rst_ct_col",    int'(a_ct_col),  0);
    chk("rst4_hd_hazir", int'(b_rdy),     1);
    chk("rst4_ct_vld",   int'(b_ct_vld),  0);

`ifdef ZZ_ZERO_FILL_EN
    // one flagged pair (3,9): 3 zeros, the 9, then 60 zeros to (7,7)
    send(0, 3, 9, 1);
    idle(90);
    chk("fill_count", qa.size(), 64);
    if (qa.size() == 64) begin
      for (int i = 0; i < 64; i++) begin
        chk($sformatf("fill[%0d].val", i), qa[i].val, (i == 3) ? 9 : 0);
        chk($sformatf("fill[%0d].son", i), qa[i].son, (i == 63) ? 1 : 0);
      end
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("fill[%0d].row", i), qa[i].row, r8[i]);
        chk($sformatf("fill[%0d].col", i), qa[i].col, c8[i]);
      end
      chk("fill_last_row", qa[63].row, 7);
      chk("fill_last_col", qa[63].col, 7);
    end
`else
    // ---- basic placement, block end, next block restarts at (0,0) ----
    t1.push_back('{0, 5,    0, 0, 0, 5,    0});
    t1.push_back('{0, -3,   0, 0, 1, 4093, 0});  // -3 as 12-bit
    t1.push_back('{2, 7,    1, 1, 1, 7,    1});
    t1.push_back('{0, 4,    0, 0, 0, 4,    0});
    t1.push_back('{1, 8,    0, 1, 0, 8,    0});
    t1.push_back('{0, 9,    0, 2, 0, 9,    0});
    t1.push_back('{3, 10,   0, 1, 2, 10,   0});
    t1.push_back('{0, 11,   1, 2, 1, 11,   1});
    t1.push_back('{0, 12,   0, 0, 0, 12,   0});
    foreach (t1[i]) send(0, t1[i].run, t1[i].val, t1[i].son);
    idle(8);
    cmp_q("t1", 0, t1);

    // ---- latency: run 3 lands 4 edges after acceptance, at pos 4 ----
    qa.delete();
    send(0, 3, 20, 0);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!a_ct_vld && lat < 50);
    chk("latency", lat, 4);
    idle(2);
    chk("lat_count", qa.size(), 1);
    if (qa.size() > 0) begin
      chk("lat_row", qa[0].row, 1);
      chk("lat_col", qa[0].col, 1);
      chk("lat_val", qa[0].val, 20);
    end

    // ---- N=4: 16 unflagged run-0 pairs, then a 17th ----
    do_reset();
    for (int i = 0; i < 16; i++) t3.push_back('{0, 100 + i, 0, r4[i], c4[i], 100 + i, (i == 15) ? 1 : 0});
    t3.push_back('{0, 116, 0, 0, 0, 116, 0});
    foreach (t3[i]) send(1, t3[i].run, t3[i].val, t3[i].son);
    idle(6);
    cmp_q("t3", 1, t3);

    // ---- overflow at pos 60 ----
    do_reset();
    send(0, 59, 100, 0);       // lands at pos 59 = (6,6), walker moves to 60
    idle(64);
    send(0, 5, 1, 0);          // 60 + 5 > 63
    idle(4);
    chk("ovf_hata", int'(a_hata), 1);
    chk("ovf_count", qa.size(), 1);
    if (qa.size() > 0) begin
      chk("ovf_b0_row", qa[0].row, 6);
      chk("ovf_b0_col", qa[0].col, 6);
      chk("ovf_b0_val", qa[0].val, 100);
    end
    send(0, 0, 2, 0);
    idle(4);
    chk("ovf_after_count", qa.size(), 2);
    if (qa.size() > 1) begin
      chk("ovf_b1_row", qa[1].row, 0);
      chk("ovf_b1_col", qa[1].col, 0);
      chk("ovf_b1_val", qa[1].val, 2);
    end
    chk("ovf_hata_sticky", int'(a_hata), 1);

    // ---- stall for 3 cycles in a run-0 stream ----
    do_reset();
    fork
      begin
        for (int i = 0; i < 8; i++) send(0, 0, 30 + i, 0);
      end
      begin
        int n = 0;
        @(negedge clk);
        while (!(a_ct_vld === 1'b1 && a_ct_row == 3'd1 && a_ct_col == 3'd0) && n < 100) begin
          @(negedge clk);
          n++;
        end
        chk("stall_trigger", int'(n < 100), 1);
        @(posedge clk); #1;
        a_ct_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("stall_vld",   int'(a_ct_vld),  1);
          chk("stall_row",   int'(a_ct_row),  2);
          chk("stall_col",   int'(a_ct_col),  0);
          chk("stall_val",   int'(a_ct_veri), 33);
          chk("stall_hazir", int'(a_rdy),     0);
        end
        @(posedge clk); #1;
        a_ct_rdy = 1'b1;
      end
    join
    idle(6);
    for (int i = 0; i < 8; i++) t5.push_back('{0, 30 + i, 0, r8[i], c8[i], 30 + i, 0});
    cmp_q("t5", 0, t5);

    // ---- reset in the middle of a skip walk ----
    do_reset();
    send(0, 6, 50, 0);
    repeat (2) @(posedge clk);   // skip now 4
    #1 rstn = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_hazir", int'(a_rdy),     1);
    chk("mid_rst_vld",   int'(a_ct_vld),  0);
    chk("mid_rst_son",   int'(a_ct_bson), 0);
    chk("mid_rst_veri",  int'(a_ct_veri), 0);
    chk("mid_rst_row",   int'(a_ct_row),  0);
    chk("mid_rst_col",   int'(a_ct_col),  0);
    chk("mid_rst_hata",  int'(a_hata),    0);
    rstn = 1'b1;
    qa.delete();
    send(0, 0, 1, 0);
    idle(10);
    chk("mid_rst_count", qa.size(), 1);
    if (qa.size() > 0) begin
      chk("mid_rst_b_row", qa[0].row, 0);
      chk("mid_rst_b_col", qa[0].col, 0);
      chk("mid_rst_b_val", qa[0].val, 1);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
